cpu_bp_update_scheduler: RTL

Shares the branch predictor's single update port between two resolution sources: the branch unit (port A) and the replay/second pipe (port B). It buffers resolved outcomes in a small FIFO, arbitrates round-robin on enqueue, and issues at most one update per cycle to the predictor under a valid/ready handshake. It also supports a queue flush and a drain sequence, used before predictor maintenance or context switch.

---
 rtl/cpu_bp_update_scheduler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cpu_bp_update_scheduler.sv
// Branch predictor update scheduler: merges two resolution ports into a small
// FIFO with round-robin arbitration, then issues one predictor update per cycle.
// Also supports queue flush and a drain sequence for maintenance/context switch.
module cpu_bp_update_scheduler #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned DEPTH_WIDTH     = 2,
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  input  logic [XLEN-1:0]            a_addr,
  input  logic                       a_taken,
  output logic                       a_ready,
  input  logic                       b_valid,
  input  logic [XLEN-1:0]            b_addr,
  input  logic                       b_taken,
  output logic                       b_ready,
  output logic                       upd_valid,
  output logic [XLEN-1:0]            upd_addr,
  output logic                       upd_taken,
  input  logic                       upd_ready,
  input  logic                       flush,
  input  logic                       drain_req,
  output logic                       drain_done,
  output logic [DEPTH_WIDTH:0]       count,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

  localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;
  localparam int unsigned CW    = DEPTH_WIDTH + 1;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StDrain   = 2'd1,
    StDrained = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [XLEN-1:0]            addr_mem_q [DEPTH];
  logic                       taken_mem_q [DEPTH];
  logic [DEPTH_WIDTH-1:0]     head_q, head_d;
  logic [DEPTH_WIDTH-1:0]     tail_q, tail_d;
  logic [DEPTH_WIDTH:0]       count_q, count_d;
  logic                       rr_b_q, rr_b_d;  // set: B wins the next tie
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

  logic grant_a, grant_b, full, en, enq, deq, refused;

  // Round-robin grant between the two ports, purely from the valids
  always_comb begin
    grant_a = a_valid & (~b_valid | ~rr_b_q);
    grant_b = b_valid & (~a_valid | rr_b_q);
  end

  // Count can only reach DEPTH, so its top bit alone flags full
  assign full    = count_q[DEPTH_WIDTH];
  assign en      = (state_q == StRun) & ~full & ~flush & ~rst;
  assign a_ready = en & grant_a;
  assign b_ready = en & grant_b;
  assign enq     = (a_valid & a_ready) | (b_valid & b_ready);
  assign refused = (a_valid & ~a_ready) | (b_valid & ~b_ready);

  assign upd_valid  = (count_q != '0) & ~rst;
  assign upd_addr   = addr_mem_q[head_q];
  assign upd_taken  = taken_mem_q[head_q];
  assign deq        = upd_valid & upd_ready;
  assign drain_done = (state_q == StDrained) & ~rst;
  assign count      = count_q;
  assign stall_cnt  = stall_q;

  // Queue pointer, occupancy, arbitration and stall counter next state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    rr_b_d  = rr_b_q;
    stall_d = stall_q;
    if (flush) begin
      // A dequeue in this cycle has already been seen by the predictor
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (enq) begin
        tail_d = tail_q + DEPTH_WIDTH'(1);
        rr_b_d = a_ready;
      end
      if (deq) begin
        head_d = head_q + DEPTH_WIDTH'(1);
      end
      count_d = count_q + CW'(enq) - CW'(deq);
    end
    if (refused && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_WIDTH'(1);
    end
  end

  // Drain sequencing FSM
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (drain_req) state_d = StDrain;
      end
      StDrain: begin
        if (!drain_req) begin
          state_d = StRun;
        end else if (flush || (count_q == '0) || ((count_q == CW'(1)) && deq)) begin
          state_d = StDrained;
        end
      end
      StDrained: begin
        if (!drain_req) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rr_b_q  <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rr_b_q  <= rr_b_d;
      stall_q <= stall_d;
    end
  end

  // Entry storage; enq is already suppressed during reset and flush
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem_q[tail_q]  <= a_ready ? a_addr : b_addr;
      taken_mem_q[tail_q] <= a_ready ? a_taken : b_taken;
    end
  end

endmodule
